// File: rtl/minibus_pkg.sv
// Shared types and constants for the 8-bit minibus initiator.
// Widths, FSM states and the CPLD card-detect signature.
package minibus_pkg;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 8;
  localparam int CD_ADDR_BIT = 13;

  localparam logic [DATA_W-1:0] CD_PRESENT = 8'hE5;
  localparam logic [DATA_W-1:0] CD_ABSENT  = 8'hAD;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/minibus_master_8bit_if.sv
// Command/response handshake plus CPLD pin bundle.
// master: the initiator block; slave: host side and pins.
interface minibus_master_8bit_if;
  import minibus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic              card_present;
  logic              cd_err;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;
  logic              cs;
  logic              rw_b;
  logic              oe;
  logic              wait_n;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_wdata, data_in, wait_n,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_timeout, card_present, cd_err,
    output address, data_out, data_oe,
    output cs, rw_b, oe
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_wdata, data_in, wait_n,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_timeout, card_present, cd_err,
    input  address, data_out, data_oe,
    input  cs, rw_b, oe
  );

endinterface

// File: rtl/minibus_sync2.sv
// Two-flop synchroniser for the asynchronous cf_wait line.
// Resets to 1 so a fresh cycle never starts out stalled.
module minibus_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/minibus_master_8bit.sv
// Minibus initiator: one command at a time into a timed
// SETUP/STROBE/HOLD/TURN bus cycle, with wait and card detect.
module minibus_master_8bit
  import minibus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 1,
  parameter int WAIT_TMO   = 255
) (
  input logic                  clk,
  input logic                  reset,
  minibus_master_8bit_if.master bus
);

  localparam logic [7:0] SETUP_N  = 8'(SETUP_CYC);
  localparam logic [7:0] STROBE_N = 8'(STROBE_CYC);
  localparam logic [7:0] HOLD_N   = 8'(HOLD_CYC);
  localparam logic [7:0] TURN_N   = 8'(TURN_CYC);
  localparam logic [7:0] TMO_N    = 8'(WAIT_TMO);

  state_e            state, state_d;
  logic [7:0]        cnt, cnt_d;
  logic [7:0]        wcnt, wcnt_d;
  logic              to_q, to_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  req_t              req_q, req_d;
  req_t              req_in, cur;
  logic              wait_s;
  logic              accept;
  logic              done;

  logic              ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_to_d;
  logic              cp_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d;
  logic              doe_d;
  logic              cs_d, rw_d, oe_d;

  minibus_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.wait_n),
    .q     (wait_s)
  );

  assign req_in = {bus.req_write, bus.req_addr, bus.req_wdata};
  assign accept = (state == IDLE) & bus.req_valid & bus.req_ready;
  // Bus pins launch from the live request on the accept edge.
  assign cur    = (state == IDLE) ? req_in : req_q;
  assign done   = (state == HOLD) & (state_d == TURN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      to_q  <= 1'b0;
      rd_q  <= '0;
      req_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      wcnt  <= wcnt_d;
      to_q  <= to_d;
      rd_q  <= rd_d;
      req_q <= req_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wcnt_d  = wcnt;
    to_d    = to_q;
    rd_d    = rd_q;
    req_d   = req_q;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = SETUP_N;
          wcnt_d  = '0;
          to_d    = 1'b0;
          rd_d    = '0;
          req_d   = req_in;
        end
      end
      (state == SETUP): begin
        if (cnt == 8'd1) begin
          state_d = STROBE;
          cnt_d   = STROBE_N;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      // Counter parks at 1 while the CPLD stretches the strobe.
      (state == STROBE): begin
        if (cnt != 8'd1) begin
          cnt_d = cnt - 8'd1;
        end else if (wait_s) begin
          state_d = HOLD;
          cnt_d   = HOLD_N;
          rd_d    = bus.data_in;
        end else if (wcnt == TMO_N) begin
          state_d = HOLD;
          cnt_d   = HOLD_N;
          to_d    = 1'b1;
        end else begin
          wcnt_d = wcnt + 8'd1;
        end
      end
      (state == HOLD): begin
        if (cnt == 8'd1) begin
          state_d = TURN;
          cnt_d   = TURN_N;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      (state == TURN): begin
        if (cnt == 8'd1) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered from the next state so they track it.
  always_comb begin
    ready_d     = (state_d == IDLE);
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_to_d    = 1'b0;
    cp_d        = bus.card_present;
    err_d       = bus.cd_err;
    addr_d      = bus.address;
    dout_d      = bus.data_out;
    doe_d       = bus.data_oe;
    rw_d        = bus.rw_b;
    cs_d        = 1'b1;
    oe_d        = 1'b1;
    unique case (1'b1)
      (state_d == SETUP): begin
        addr_d = cur.addr;
        dout_d = cur.wdata;
        doe_d  = cur.write;
        rw_d   = ~cur.write;
      end
      (state_d == STROBE): begin
        cs_d = 1'b0;
        oe_d = cur.write;
      end
      (state_d == TURN), (state_d == IDLE): begin
        doe_d = 1'b0;
        rw_d  = 1'b1;
      end
      default: begin
      end
    endcase
    if (done) begin
      rsp_valid_d = 1'b1;
      rsp_to_d    = to_q;
      if (!to_q && !req_q.write) rsp_rdata_d = rd_q;
      if (!to_q && !req_q.write && req_q.addr[CD_ADDR_BIT]) begin
        if (rd_q == CD_PRESENT) begin
          cp_d  = 1'b1;
          err_d = 1'b0;
        end else if (rd_q == CD_ABSENT) begin
          cp_d  = 1'b0;
          err_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.rsp_timeout  <= 1'b0;
      bus.card_present <= 1'b0;
      bus.cd_err       <= 1'b0;
      bus.address      <= '0;
      bus.data_out     <= '0;
      bus.data_oe      <= 1'b0;
      bus.cs           <= 1'b1;
      bus.rw_b         <= 1'b1;
      bus.oe           <= 1'b1;
    end else begin
      bus.req_ready    <= ready_d;
      bus.rsp_valid    <= rsp_valid_d;
      bus.rsp_rdata    <= rsp_rdata_d;
      bus.rsp_timeout  <= rsp_to_d;
      bus.card_present <= cp_d;
      bus.cd_err       <= err_d;
      bus.address      <= addr_d;
      bus.data_out     <= dout_d;
      bus.data_oe      <= doe_d;
      bus.cs           <= cs_d;
      bus.rw_b         <= rw_d;
      bus.oe           <= oe_d;
    end
  end

endmodule

// File: tb/tb_minibus_master_8bit.sv
// Directed and randomized bus cycles against a cycle-count
// reference model of the minibus initiator.
module tb_minibus_master_8bit;
  import minibus_pkg::*;

  localparam int S_CYC  = 1;
  localparam int ST_CYC = 4;
  localparam int H_CYC  = 1;
  localparam int T_CYC  = 1;
  localparam int TMO    = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   cp_m = 1'b0;
  bit   err_m = 1'b0;

  minibus_master_8bit_if bus ();

  minibus_master_8bit #(
    .SETUP_CYC  (S_CYC),
    .STROBE_CYC (ST_CYC),
    .HOLD_CYC   (H_CYC),
    .TURN_CYC   (T_CYC),
    .WAIT_TMO   (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe length from the wait window: the synchronised wait
  // seen at strobe clk k is what was driven at clk k-2.
  task automatic model(input int s, input int len,
                       output int l, output bit to);
    int j;
    bit low;
    bit found;
    l = ST_CYC + TMO;
    to = 1'b1;
    found = 1'b0;
    for (int k = ST_CYC; k <= ST_CYC + TMO; k++) begin
      j = k - 2;
      low = (j >= 1) && (j >= s) && (j < s + len);
      if (!found && !low) begin
        l = k;
        to = 1'b0;
        found = 1'b1;
      end
    end
  endtask

  task automatic xact(input logic wr, input logic [19:0] addr,
                      input logic [7:0] wd, input logic [7:0] din,
                      input int ws_start, input int ws_len);
    int l, n, cs_n, oe_n, doe_n, rsp_n, rsp_at, busy;
    bit to, done, lowc;
    logic [7:0] rsp_d, do_seen, exp_rd;
    logic [19:0] a_seen;
    logic rw_seen, rsp_to;
    model(ws_start, ws_len, l, to);
    n = 0; cs_n = 0; oe_n = 0; doe_n = 0; rsp_n = 0;
    rsp_at = 0; busy = 0; done = 1'b0;
    rsp_d = 8'h00; do_seen = 8'h00; a_seen = '0;
    rw_seen = 1'b0; rsp_to = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge clk);
    while (!done && n < 1000) begin
      n++;
      lowc = (bus.cs === 1'b0);
      if (lowc) begin
        cs_n++;
        if (cs_n == 1) begin
          a_seen = bus.address;
          rw_seen = bus.rw_b;
        end
      end
      if (bus.oe === 1'b0) oe_n++;
      if (bus.data_oe === 1'b1) begin
        doe_n++;
        if (doe_n == 1) do_seen = bus.data_out;
      end
      if (bus.rsp_valid === 1'b1) begin
        rsp_n++;
        rsp_at = n;
        rsp_d = bus.rsp_rdata;
        rsp_to = bus.rsp_timeout;
      end
      if (bus.req_ready === 1'b1) done = 1'b1;
      else busy++;
      bus.wait_n = !(lowc && cs_n >= ws_start &&
                     cs_n < ws_start + ws_len);
      bus.data_in = lowc ? din : 8'($urandom);
      if (done) begin
        bus.req_valid = 1'b0;
      end else begin
        bus.req_valid = 1'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_addr  = 20'($urandom);
        bus.req_wdata = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.wait_n = 1'b1;
    exp_rd = (!wr && !to) ? din : 8'h00;
    if (!wr && !to && addr[CD_ADDR_BIT]) begin
      if (din == CD_PRESENT) begin
        cp_m = 1'b1; err_m = 1'b0;
      end else if (din == CD_ABSENT) begin
        cp_m = 1'b0; err_m = 1'b0;
      end else begin
        err_m = 1'b1;
      end
    end
    chk("ready_return", 32'(done), 32'd1);
    chk("cs_low_clks", cs_n, l);
    chk("oe_low_clks", oe_n, wr ? 0 : l);
    chk("data_oe_clks", doe_n, wr ? S_CYC + l + H_CYC : 0);
    chk("address", 32'(a_seen), 32'(addr));
    chk("rw_b", 32'(rw_seen), 32'(!wr));
    if (wr) chk("data_out", 32'(do_seen), 32'(wd));
    chk("rsp_count", rsp_n, 1);
    chk("rsp_at", rsp_at, S_CYC + l + H_CYC + 1);
    chk("rsp_rdata", 32'(rsp_d), 32'(exp_rd));
    chk("rsp_timeout", 32'(rsp_to), 32'(to));
    chk("busy_clks", busy, S_CYC + l + H_CYC + T_CYC);
    chk("card_present", 32'(bus.card_present), 32'(cp_m));
    chk("cd_err", 32'(bus.cd_err), 32'(err_m));
    chk("idle_cs", 32'(bus.cs), 32'd1);
    chk("idle_oe", 32'(bus.oe), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_cs"}, 32'(bus.cs), 32'd1);
    chk({tag, "_oe"}, 32'(bus.oe), 32'd1);
    chk({tag, "_rw_b"}, 32'(bus.rw_b), 32'd1);
    chk({tag, "_data_oe"}, 32'(bus.data_oe), 32'd0);
    chk({tag, "_card"}, 32'(bus.card_present), 32'd0);
    chk({tag, "_cd_err"}, 32'(bus.cd_err), 32'd0);
  endtask

  task automatic rst_mid();
    int n, csn;
    n = 0;
    csn = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 20'h00123;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (csn < 2 && n < 50) begin
      if (bus.cs === 1'b0) csn++;
      if (csn < 2) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_in_strobe", csn, 2);
    reset = 1'b1;
    @(negedge clk);
    cp_m = 1'b0;
    err_m = 1'b0;
    check_idle("rst_mid");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    logic        wr;
    logic [19:0] a;
    logic [7:0]  d;
    int          pick;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.data_in   = '0;
    bus.wait_n    = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset_address", 32'(bus.address), 32'd0);
    chk("reset_data_out", 32'(bus.data_out), 32'd0);
    chk("reset_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("reset_timeout", 32'(bus.rsp_timeout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    xact(1'b1, 20'h00042, 8'h5A, 8'h77, 0, 0);
    xact(1'b0, 20'h00010, 8'h00, 8'h3C, 0, 0);
    xact(1'b0, 20'h02000, 8'h00, 8'hE5, 0, 0);
    xact(1'b0, 20'h02000, 8'h00, 8'hAD, 0, 0);
    xact(1'b0, 20'h02000, 8'h00, 8'h12, 0, 0);
    xact(1'b0, 20'h02000, 8'h00, 8'hE5, 0, 0);
    xact(1'b0, 20'h02000, 8'h00, 8'h34, 0, 0);
    xact(1'b0, 20'h00300, 8'h00, 8'h96, 1, 10);
    xact(1'b1, 20'h00301, 8'hC3, 8'h00, 1, 10);
    xact(1'b0, 20'h02000, 8'h00, 8'hAD, 1, 100000);

    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom);
      a = 20'($urandom);
      if ($urandom_range(0, 2) == 0) a[CD_ADDR_BIT] = 1'b1;
      pick = $urandom_range(0, 3);
      d = (pick == 0) ? CD_PRESENT :
          (pick == 1) ? CD_ABSENT : 8'($urandom);
      if ($urandom_range(0, 1) == 0)
        xact(wr, a, 8'($urandom), d, 0, 0);
      else
        xact(wr, a, 8'($urandom), d,
             $urandom_range(1, 4), $urandom_range(0, 12));
    end

    xact(1'b0, 20'h02000, 8'h00, 8'hE5, 0, 0);
    rst_mid();
    xact(1'b1, 20'h0ABCD, 8'hA5, 8'h00, 0, 0);
    xact(1'b0, 20'h02000, 8'h00, 8'hE5, 2, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
